// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment codes and anode helper for the multiplexed 7-segment driver.
package seg7_pkg;
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   // Active-low {g,f,e,d,c,b,a}; entry 15 is first in the concatenation
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };
   function automatic logic [7:0] an_onehot(input logic [2:0] idx, input logic act_low);
      return act_low ? ~(8'b1 << idx) : 8'b1 << idx;
   endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment code.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed common-anode 7-segment driver with blank gap per digit.
// Optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int SCAN_DIV      = 50000,
   parameter int AN_ACTIVE_LOW = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_in,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  scan_tick
);
   localparam int IW = $clog2(N_DIGITS);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [N_DIGITS-1:0][3:0] sh_val;
   logic [N_DIGITS-1:0] sh_dp;
   logic upd, tick, blank;
   logic [6:0] dec_seg;
   logic [7:0] an_sel;
   assign tick   = cnt == CW'(SCAN_DIV - 1);
   assign an_sel = an_onehot(3'(idx), AN_ACTIVE_LOW != 0);
   seg7_hex_decode u_dec (.nib(sh_val[idx]), .seg(dec_seg));
`ifdef SEG7_SCAN_LZB_EN
   logic [N_DIGITS-1:0] zero_up;
   // zero_up[i]: nibble i and every more-significant nibble are zero
   always_comb begin
      logic run;
      run = 1'b1;
      zero_up = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         run = run & (sh_val[i] == 4'd0);
         zero_up[i] = run;
      end
   end
   assign blank = (idx != '0) && zero_up[idx] && !sh_dp[idx];
`else
   assign blank = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         idx       <= '0;
         sh_val    <= '0;
         sh_dp     <= '0;
         an        <= AN_OFF;
         seg       <= SEG_OFF;
         dp        <= 1'b1;
         scan_tick <= 1'b0;
         upd       <= 1'b1;
      end else begin
         cnt       <= tick ? '0 : cnt + 1'b1;
         scan_tick <= tick;
         if (load) begin
            sh_val <= value;
            sh_dp  <= dp_in;
         end
         if (tick) begin
            idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            an  <= AN_OFF;
            upd <= 1'b1;
         end else if (upd) begin
            an  <= an_sel[N_DIGITS-1:0];
            seg <= blank ? SEG_OFF : dec_seg;
            dp  <= blank | ~sh_dp[idx];
            upd <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed self-checking bench for seg7_scan_mux (N=4, SCAN_DIV=4).
module tb_seg7_scan_mux;
   logic clk = 1'b0, reset = 1'b1, load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0] dp_in = '0, an;
   logic [6:0] seg;
   logic dp, scan_tick;
   int n_chk = 0, n_fail = 0;
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
      S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000, SA = 7'b0001000,
      SF = 7'b0001110, OFF = 7'b1111111;
   seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(4), .AN_ACTIVE_LOW(0)) dut (
      .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
      .an(an), .seg(seg), .dp(dp), .scan_tick(scan_tick)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   // one full slot starting at the refresh edge: 3 driven cycles then the blank cycle
   task automatic run_slot(input int d, input logic [6:0] es, input logic edp);
      step();
      check($sformatf("an d%0d", d), 32'(an), 32'(4'b1 << d));
      check($sformatf("seg d%0d", d), 32'(seg), 32'(es));
      check($sformatf("dp d%0d", d), 32'(dp), 32'(edp));
      check($sformatf("tick low d%0d", d), 32'(scan_tick), 0);
      step();
      check($sformatf("an hold d%0d", d), 32'(an), 32'(4'b1 << d));
      step();
      check($sformatf("seg hold d%0d", d), 32'(seg), 32'(es));
      step();
      check($sformatf("blank an d%0d", d), 32'(an), 0);
      check($sformatf("tick d%0d", d), 32'(scan_tick), 1);
   endtask
   initial begin
      logic [6:0] lz;
      repeat (3) step();
      check("rst an", 32'(an), 0);
      check("rst seg", 32'(seg), 32'(OFF));
      check("rst dp", 32'(dp), 1);
      check("rst tick", 32'(scan_tick), 0);
      reset = 1'b0;
      step();
      check("first an", 32'(an), 1);
      check("first seg", 32'(seg), 32'(S0));
      load = 1'b1; value = 16'h3A7F; dp_in = 4'b0100;
      step();
      load = 1'b0;
      check("no midslot change", 32'(seg), 32'(S0));
      step();
      step();
      check("blank after d0", 32'(an), 0);
      check("tick after d0", 32'(scan_tick), 1);
      run_slot(1, S7, 1'b1);
      run_slot(2, SA, 1'b0);
      run_slot(3, S3, 1'b1);
      run_slot(0, SF, 1'b1);
      // mid-slot load while digit 1 is shown
      step();
      check("d1 shown", 32'(seg), 32'(S7));
      load = 1'b1; value = 16'h1111; dp_in = 4'b0000;
      step();
      load = 1'b0;
      check("old code kept", 32'(seg), 32'(S7));
      step();
      check("old code kept 2", 32'(seg), 32'(S7));
      step();
      run_slot(2, S1, 1'b1);
      // load coinciding with refresh edge of digit 3 uses the old shadow
      load = 1'b1; value = 16'h2222;
      step();
      load = 1'b0;
      check("coincide an", 32'(an), 32'(4'b1000));
      check("coincide seg", 32'(seg), 32'(S1));
      repeat (3) step();
      step();
      check("wrap an", 32'(an), 1);
      check("new code d0", 32'(seg), 32'(S2));
      load = 1'b1; value = 16'h0050; dp_in = 4'b0000;
      step();
      load = 1'b0;
      repeat (2) step();
`ifdef SEG7_SCAN_LZB_EN
      lz = OFF;
`else
      lz = S0;
`endif
      run_slot(1, S5, 1'b1);
      run_slot(2, lz, 1'b1);
      run_slot(3, lz, 1'b1);
      run_slot(0, S0, 1'b1);
      // reset asserted mid-slot while digit 2 is shown
      repeat (4) step();
      step();
      check("d2 before rst", 32'(an), 32'(4'b0100));
      step();
      reset = 1'b1;
      step();
      check("midrst an", 32'(an), 0);
      check("midrst cnt", 32'(dut.cnt), 0);
      check("midrst seg", 32'(seg), 32'(OFF));
      check("midrst dp", 32'(dp), 1);
      reset = 1'b0;
      step();
      check("resume an", 32'(an), 1);
      check("resume seg", 32'(seg), 32'(S0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
